// File: rtl/lspc_timer.sv
// lspc_timer: LSPC programmable raster timer with reload sources, PAL stop window and expiry IRQ
module lspc_timer #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CLK_EN_PIX,
    input  logic [15:0]      DIN,
    input  logic             WR_MODE,
    input  logic             WR_TIMER_HIGH,
    input  logic             WR_TIMER_LOW,
    input  logic             WR_TIMER_STOP,
    input  logic             VBLANK_START,
    input  logic             PAL,
    input  logic             LINE_STOP,
    output logic             TIMER_IRQ,
    output logic             TIMER_IRQ_EN,
    output logic             RUNNING,
    output logic [CNT_W-1:0] COUNT
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] reload, count, count_nx, reload_val;
    logic             irq_en, reload_on_low_write, reload_at_vblank, reload_on_zero, stop_en;
    logic             irq, irq_nx, tick, do_reload;

    // Reload sources use the mode bits held before this edge; a low write reloads with its fresh low half
    always_comb begin
        do_reload  = (WR_TIMER_LOW & reload_on_low_write) | (VBLANK_START & reload_at_vblank);
        reload_val = WR_TIMER_LOW ? {reload[CNT_W-1:16], DIN} : reload;
        tick       = CLK_EN_PIX & (state == RUN) & ~(stop_en & PAL & LINE_STOP);
    end

    // Next state/count: a reload wins over a coincident tick, expiry is detected at zero before decrement
    always_comb begin
        state_nx = state;
        count_nx = count;
        irq_nx   = 1'b0;
        if (do_reload) begin
            count_nx = reload_val;
            state_nx = RUN;
        end else if (tick && count != '0) begin
            count_nx = count - CNT_W'(1);
        end else if (tick) begin
            irq_nx   = irq_en;
            count_nx = reload_on_zero ? reload : '0;
            state_nx = reload_on_zero ? RUN : IDLE;
        end
    end

    // Counter state, run flag and the one-cycle expiry pulse
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            count <= '0;
            irq   <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            irq   <= irq_nx;
        end
    end

    // 68k-visible registers, written on their strobes regardless of the pixel tick
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            reload              <= '0;
            irq_en              <= 1'b0;
            reload_on_low_write <= 1'b0;
            reload_at_vblank    <= 1'b0;
            reload_on_zero      <= 1'b0;
            stop_en             <= 1'b0;
        end else begin
            if (WR_TIMER_HIGH) reload[CNT_W-1:16] <= DIN[CNT_W-17:0];
            if (WR_TIMER_LOW) reload[15:0] <= DIN;
            if (WR_MODE) {reload_on_zero, reload_at_vblank, reload_on_low_write, irq_en} <= DIN[7:4];
            if (WR_TIMER_STOP) stop_en <= DIN[0];
        end
    end

    assign TIMER_IRQ    = irq;
    assign TIMER_IRQ_EN = irq_en;
    assign RUNNING      = (state == RUN);
    assign COUNT        = count;
endmodule

// File: doc/lspc_timer.md
Name: lspc_timer

Overview:
- LSPC programmable raster timer; the stage directly upstream of the interrupt priority encoder.
- Holds the 32-bit timer reload value and the timer mode bits written by the 68k. Counts pixel-clock ticks and raises TIMER_IRQ when the count expires.
- Drives TIMER_IRQ and TIMER_IRQ_EN straight into the IRQ latch/encoder.

Parameters:
CNT_W, 32, counter and reload register width (high half = DIN bits [15:0] on WR_TIMER_HIGH)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
CLK_EN_PIX  in  1  one-CLK-wide pixel-rate tick (6 MHz); the counter decrements only on this
DIN  in  16  68k write data
WR_MODE  in  1  one-cycle strobe; DIN[7:4] -> mode bits
WR_TIMER_HIGH  in  1  one-cycle strobe; DIN -> reload[31:16]
WR_TIMER_LOW  in  1  one-cycle strobe; DIN -> reload[15:0]
WR_TIMER_STOP  in  1  one-cycle strobe; DIN[0] -> stop_en
VBLANK_START  in  1  one-CLK pulse at first vblank line
PAL  in  1  video standard, 1 = PAL
LINE_STOP  in  1  high while the raster is in the PAL top/bottom 16-line stop window
TIMER_IRQ  out  1  one-CLK pulse on expiry
TIMER_IRQ_EN  out  1  mode bit 4, level
RUNNING  out  1  counter active (debug/verification)
COUNT  out  CNT_W  current counter value (debug/verification)

Behaviour:
- Reset (async) clears: reload=0, count=0, mode bits=0, stop_en=0, RUNNING=0. TIMER_IRQ=0, TIMER_IRQ_EN=0.
- Mode bits from DIN on WR_MODE:
  - [4] irq_en (drives TIMER_IRQ_EN)
  - [5] reload_on_low_write
  - [6] reload_at_vblank
  - [7] reload_on_zero
- Register writes take effect at the CLK edge of the strobe. They are not gated by CLK_EN_PIX.
- States: IDLE (RUNNING=0) and RUN (RUNNING=1).
- Any reload sets count <= reload and enters RUN. Reload sources:
  - (a) WR_TIMER_LOW with reload_on_low_write=1. Uses the new low half concatenated with the current high register in the same cycle.
  - (b) VBLANK_START with reload_at_vblank=1.
- WR_TIMER_HIGH never reloads.
- Tick = CLK_EN_PIX & RUNNING & ~(stop_en & PAL & LINE_STOP). A stopped tick leaves count unchanged. NTSC ignores stop_en.
- On a tick:
  - If count != 0: count <= count-1.
  - If count == 0: expiry.
    - TIMER_IRQ=1 for exactly the next CLK cycle, only if irq_en=1. Expiry with irq_en=0 is silent but still reloads/stops.
    - If reload_on_zero=1: count <= reload, stay in RUN.
    - Else: go to IDLE, count held at 0.
- Period: reload value R gives expiry every R+1 ticks. R=0 with reload_on_zero expires on every tick.
- Precedence within one CLK:
  - Reload (a) or (b) beats a coincident tick/expiry: no IRQ, count = reload.
  - (a) and (b) together: a single reload.
  - WR_MODE in the same cycle as a tick: the tick uses the old mode bits.
- Clearing irq_en does not cancel a TIMER_IRQ pulse already driven. Acknowledgement lives downstream.
- Counter arithmetic is unsigned CNT_W. There is no underflow wrap; expiry is detected at 0 before decrement.
- Latency: reload strobe -> COUNT valid next cycle. Expiry tick -> TIMER_IRQ next cycle.
- Reset mid-run returns to IDLE immediately. Any pending TIMER_IRQ pulse is dropped.

Test Plan:
- Write HIGH=0x0000, LOW=0x0004 with mode=0xB0 (irq_en, reload_on_low_write, reload_on_zero) -> RUN, COUNT=4. TIMER_IRQ pulses every 5 CLK_EN_PIX ticks, each pulse 1 CLK wide.
- mode=0x30 (no repeat), LOW=0x0002 -> exactly one TIMER_IRQ after 3 ticks, then RUNNING=0, COUNT stays 0 and no further pulses.
- mode=0xD0, reload=0x00000010, VBLANK_START pulse in the same cycle as the expiry tick -> no IRQ, COUNT=0x10.
- PAL=1, stop_en=1, LINE_STOP held for 8 ticks mid-count -> COUNT frozen for those ticks, expiry delayed by 8 ticks. Same stimulus with PAL=0 -> no delay.
- reload=0, mode=0xB0 -> TIMER_IRQ on every tick. Then mode=0xA0 -> counting continues with no pulses and TIMER_IRQ_EN=0.
- Assert RESET asynchronously while RUN with COUNT=3 -> all outputs 0 immediately. No TIMER_IRQ after release until reloaded.
